// File: rtl/core_pkg.sv
// Core-side shared types used by data-memory peripherals.
package core_pkg;

  typedef struct packed {
    logic memRead;
    logic memWrite;
  } mem_ctrl_t;

endpackage

// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard MMIO receiver.
package ps2_kbd_pkg;

  // Word offsets decoded from i_addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS register bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_OCC_LSB   = 8;

  localparam int CTRL_RX_EN = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous scan-code FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (cnt == '0);
  assign full     = (cnt == DEPTH_L);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign count    = cnt;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_mmio.sv
// Memory-mapped PS/2 keyboard receiver with scan-code FIFO and W1C status.
// Optional build macro PS2_KBD_PARITY_CHECK_EN drops bytes with bad parity.
module ps2_kbd_mmio
  import core_pkg::*;
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  input  mem_ctrl_t   i_ctrl,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writeData,
  output logic [31:0] o_readData,
  output logic        o_irq,
  output ps2_state_e  o_dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  // Handshake: a load or store is a single-cycle strobe (memRead/memWrite);
  // there is no ready/stall, the access completes on the clock edge ending it.

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       ps2_fall;
  logic       ps2_bit;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync[1];
  assign ps2_bit  = data_sync[1];

  ps2_state_e      state, state_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   tmo_cnt, tmo_d;
  logic            rx_en_q;
  logic            parity_good;
  logic            rx_push;
  logic            frame_bad;

`ifdef PS2_KBD_PARITY_CHECK_EN
  assign parity_good = odd_parity_ok(shift_q, parity_q);
`else
  assign parity_good = 1'b1;
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tmo_cnt  <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_cnt;
    rx_push   = 1'b0;
    frame_bad = 1'b0;
    if (!rx_en_q) begin
      state_d = IDLE;
      tmo_d   = '0;
    end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
      // Stalled partial frame is abandoned silently.
      state_d = IDLE;
      tmo_d   = '0;
    end else begin
      if (state != IDLE) tmo_d = ps2_fall ? '0 : tmo_cnt + 1'b1;
      if (ps2_fall) begin
        case (state)
          IDLE: begin
            if (!ps2_bit) begin
              state_d   = DATA;
              bit_cnt_d = '0;
              tmo_d     = '0;
            end
          end
          DATA: begin
            shift_d   = {ps2_bit, shift_q[7:1]};
            bit_cnt_d = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state_d = PARITY;
          end
          PARITY: begin
            parity_d = ps2_bit;
            state_d  = STOP;
          end
          STOP: begin
            if (ps2_bit && parity_good) rx_push   = 1'b1;
            else                        frame_bad = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign o_dbg_state = state;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_ovf;
  logic          data_pop;
  logic [1:0]    sel;
  logic          store_status;
  logic          store_ctrl;

  assign sel          = i_addr[3:2];
  assign data_pop     = i_ctrl.memRead && (sel == REG_DATA);
  assign store_status = i_ctrl.memWrite && (sel == REG_STATUS);
  assign store_ctrl   = i_ctrl.memWrite && (sel == REG_CTRL);

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_reset),
    .push     (rx_push),
    .pop      (data_pop),
    .din      (shift_q),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  logic overflow_q;
  logic frame_err_q;

  // A new error event in the same cycle as a W1C clear keeps the bit set.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_en_q     <= 1'b1;
    end else begin
      overflow_q  <= fifo_ovf  | (overflow_q  & ~(store_status & i_writeData[ST_OVERFLOW]));
      frame_err_q <= frame_bad | (frame_err_q & ~(store_status & i_writeData[ST_FRAME_ERR]));
      if (store_ctrl) rx_en_q <= i_writeData[CTRL_RX_EN];
    end
  end

  always_comb begin
    o_readData = '0;
    if (i_ctrl.memRead) begin
      case (sel)
        REG_DATA: begin
          if (!fifo_empty) o_readData[7:0] = fifo_dout;
        end
        REG_STATUS: begin
          o_readData[ST_NOT_EMPTY]         = !fifo_empty;
          o_readData[ST_OVERFLOW]          = overflow_q;
          o_readData[ST_FRAME_ERR]         = frame_err_q;
          o_readData[ST_OCC_LSB +: CW]     = fifo_count;
        end
        REG_CTRL: o_readData[CTRL_RX_EN] = rx_en_q;
        default:  o_readData = '0;
      endcase
    end
  end

  assign o_irq = !fifo_empty;

  logic unused_bits;
  assign unused_bits = ^{i_addr[31:4], i_addr[1:0], i_writeData[31:3], fifo_full};

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// Directed plus randomized bench for ps2_kbd_mmio against a queue-based reference model.
module tb_ps2_kbd_mmio;
  import core_pkg::*;
  import ps2_kbd_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 5000;
`ifdef PS2_KBD_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  mem_ctrl_t   ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  ps2_state_e  dbg_state;

  ps2_kbd_mmio #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .i_ctrl      (ctrl),
    .i_addr      (addr),
    .i_writeData (wdata),
    .o_readData  (rdata),
    .o_irq       (irq),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: expected FIFO contents and sticky flags
  logic [7:0] exp_q[$];
  bit m_ovf;
  bit m_ferr;
  bit m_rx_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (exp_q.size() != 0);
    s[1]    = m_ovf;
    s[2]    = m_ferr;
    s[15:8] = 8'(exp_q.size());
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
    m_rx_en = 1'b1;
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (6) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_at_stop);
    logic [10:0] bits;
    logic [31:0] popped;
    logic [31:0] exp_pop;
    bit          good;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    popped = '0;
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    @(negedge clk);
    ps2_data = bits[10];
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      // load lands in the same cycle the stop-bit edge pushes
      repeat (2) @(negedge clk);
      addr = 32'h0;
      ctrl.memRead = 1'b1;
      #1 popped = rdata;
      @(negedge clk);
      ctrl.memRead = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    if (pop_at_stop) begin
      exp_pop = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
      check("pop_at_stop", popped, exp_pop);
    end
    if (m_rx_en) begin
      good = !bad_stop && !(PAR_CHK && bad_par);
      if (!good)                       m_ferr = 1'b1;
      else if (exp_q.size() < DEPTH)   exp_q.push_back(b);
      else                             m_ovf = 1'b1;
    end
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    ctrl.memRead = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    ctrl.memRead = 1'b0;
    addr = '0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    addr  = a;
    wdata = v;
    ctrl.memWrite = 1'b1;
    @(negedge clk);
    ctrl.memWrite = 1'b0;
    wdata = '0;
    if (a[3:2] == 2'd1) begin
      if (v[1]) m_ovf  = 1'b0;
      if (v[2]) m_ferr = 1'b0;
    end else if (a[3:2] == 2'd2) begin
      m_rx_en = v[0];
    end
  endtask

  task automatic load_data_chk(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
    do_load(32'h0, d);
    check(tag, d, e);
  endtask

  task automatic load_status_chk(input string tag);
    logic [31:0] d;
    do_load(32'h4, d);
    check(tag, d, model_status());
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    ctrl = '0;
    addr = '0;
    wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // reset state
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata_idle", rdata, 32'h0);
    check("rst_fsm", 32'(dbg_state), 32'(IDLE));
    load_status_chk("rst_status");
    do_load(32'h8, rd); check("rst_ctrl", rd, 32'h1);
    do_load(32'hC, rd); check("rst_rsvd", rd, 32'h0);
    load_data_chk("rst_data_empty");

    // single valid frame
    send_frame(8'h1C, 0, 0, 0);
    check("irq_after_push", {31'h0, irq}, 32'h1);
    check("rdata_no_read", rdata, 32'h0);
    load_data_chk("data_1c");
    check("irq_after_pop", {31'h0, irq}, 32'h0);
    load_status_chk("status_after_1c");

    // overflow with 9 bytes
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    load_status_chk("status_overflow");
    check("overflow_model", model_status(), 32'h0000_0803);
    for (int i = 0; i < DEPTH; i++) load_data_chk("drain_ovf");
    do_store(32'h4, 32'h2);
    load_status_chk("ovf_w1c");

    // parity error and bad stop bit
    send_frame(8'h1C, 1, 0, 0);
    load_status_chk("parity_err_status");
    do_store(32'h4, 32'h4);
    load_status_chk("parity_err_w1c");
    load_data_chk("parity_err_data");
    send_frame(8'h2A, 0, 1, 0);
    load_status_chk("stop_err_status");
    do_store(32'h4, 32'h6);
    load_status_chk("stop_err_w1c");

    // partial frame abandoned by timeout
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    repeat (TMO + 5) @(negedge clk);
    send_frame(8'hF0, 0, 0, 0);
    load_status_chk("timeout_status");
    load_data_chk("timeout_data_f0");

    // pop and push in the same cycle on a full FIFO
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 0, 0, 0);
    send_frame(8'h18, 0, 0, 1);
    load_status_chk("full_push_pop_status");
    for (int i = 0; i < DEPTH; i++) load_data_chk("drain_full_pop");

    // receiver disabled ignores frames
    do_store(32'h8, 32'h0);
    do_load(32'h8, rd); check("ctrl_disabled", rd, 32'h0);
    send_frame(8'h55, 0, 0, 0);
    load_status_chk("disabled_status");
    do_store(32'h8, 32'h1);
    do_load(32'h8, rd); check("ctrl_enabled", rd, 32'h1);

    // reset mid-frame with bytes queued
    send_frame(8'hA1, 0, 0, 0);
    send_frame(8'hB2, 0, 0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("midreset_irq", {31'h0, irq}, 32'h0);
    load_status_chk("midreset_status");
    send_frame(8'h3C, 0, 0, 0);
    load_data_chk("after_reset_data");

    // randomized traffic
    repeat (40) begin
      case ($urandom_range(0, 4))
        0, 1: send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                         ($urandom_range(0, 7) == 0), 1'b0);
        2: load_data_chk("rand_data");
        3: load_status_chk("rand_status");
        default: do_store(32'h4, 32'($urandom_range(0, 7)));
      endcase
    end
    load_status_chk("rand_final_status");
    for (int i = 0; i <= DEPTH; i++) load_data_chk("rand_drain");
    load_status_chk("rand_drained_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
